divider_seq: RTL and testbench
==============================

Name: divider_seq

Overview:
Sequential restoring integer divider, the inverse operation of the team's multiplier blocks.
- Computes quotient and remainder of a bw-bit dividend by a bw-bit divisor, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the multipliers in the arithmetic datapath; results are registered and held until the next accepted start.

Parameters:
bw, 16, operand width in bits; quotient and remainder are also bw bits.

Ports:
CLK  input  1  clock, rising edge.
RESETn  input  1  reset, asynchronous, active-low.
start  input  1  request a division; sampled on the rising CLK edge.
A  input  bw  dividend; captured when start is accepted.
B  input  bw  divisor; captured when start is accepted.
busy  output  1  high while a division is in progress.
done  output  1  single-cycle pulse when results are valid.
quotient  output  bw  registered quotient.
remainder  output  bw  registered remainder.
div_by_zero  output  1  set with done when the captured B was 0.

Behaviour:
- Reset: all outputs are 0, state is IDLE, internal registers are cleared. Reset takes effect immediately, including mid-operation; any in-flight division is discarded and no done is produced.
- States: IDLE, CALC, DONE.
- IDLE/DONE, start=1: capture A and B and clear div_by_zero.
  - B!=0: go to CALC with busy=1, iteration counter = bw-1, partial remainder R = 0, Q = A.
  - B==0: go to DONE. quotient = all ones, remainder = A, div_by_zero = 1.
- IDLE/DONE, start=0: go to or stay in IDLE. Outputs hold their last values.
- CALC, each cycle:
  - Shift {R,Q} left by 1.
  - Trial subtraction T = R - B, computed at bw+1 bits.
  - If T >= 0: R = T and Q[0] = 1. Otherwise R is restored and Q[0] = 0.
  - Counter decrements. When the counter hits 0, load quotient = Q and remainder = R, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
- Latency, with the start edge as edge 0:
  - Normal division: done is high in the cycle after edge bw+1. That is bw+1 cycles of latency, of which busy is high for bw cycles.
  - Divide-by-zero: latency is 1 cycle.
- start while busy=1 is ignored; there is no queuing, and A/B changes during CALC have no effect.
- start asserted in the same cycle as done is accepted; back-to-back operation has no idle cycle.
- Unsigned arithmetic. Invariant: A = quotient*B + remainder, with remainder < B.

Optional Feature:
Macro DIVIDER_SIGNED_EN.
- Defined: A and B are two's complement.
  - Magnitudes are divided by the same CALC sequence and the signs are fixed up in the cycle that loads the outputs; latency is unchanged.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case, A = -2^(bw-1) and B = -1: quotient = -2^(bw-1) (wraps), remainder = 0, div_by_zero = 0.
  - Divide-by-zero: quotient = all ones, remainder = A.
- Undefined: purely unsigned as in Behaviour; no sign logic is synthesized.

Test Plan:
- bw=16, A=100, B=7, start pulse -> busy high for 16 cycles; done pulse 17 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- A=0xFFFF, B=1; then A=3, B=0xFFFF -> first: quotient=0xFFFF, remainder=0. Second: quotient=0, remainder=3.
- A=5, B=0 -> done 1 cycle after start; quotient=0xFFFF, remainder=5, div_by_zero=1.
- A=100, B=7 started, then start with A=9, B=3 at cycle 5; then start held high in the done cycle with A=9, B=3 -> the cycle-5 start is ignored, first result is 14/2. The second division is accepted back-to-back and done fires 17 cycles later with quotient=3, remainder=0.
- RESETn pulsed low at cycle 8 of a division -> outputs are 0 immediately, no done pulse; a new start after release gives a correct result.
- DIVIDER_SIGNED_EN: A=-7 (0xFFF9), B=2 -> quotient=0xFFFD (-3), remainder=0xFFFF (-1). A=0x8000, B=0xFFFF -> quotient=0x8000, remainder=0.

Source files
------------

// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement operands (sign fix-up at output load).
`timescale 1ns/1ps
module divider_seq #(
  parameter int unsigned bw = 16
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          start,
  input  logic [bw-1:0] A,
  input  logic [bw-1:0] B,
  output logic          busy,
  output logic          done,
  output logic [bw-1:0] quotient,
  output logic [bw-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (bw > 1) ? $clog2(bw) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [bw-1:0] r_q, r_d;
  logic [bw-1:0] q_q, q_d;
  logic [bw-1:0] b_q, b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [bw-1:0] quot_q, quot_d;
  logic [bw-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [bw:0]   r_shift;
  logic          trial_ge;
  logic [bw-1:0] r_next;
  logic [bw-1:0] q_next;
  logic [bw-1:0] a_mag;
  logic [bw-1:0] b_mag;
  logic [bw-1:0] quot_fix;
  logic [bw-1:0] rem_fix;

  // One restoring step: shift {R,Q}, trial-subtract B, keep or restore.
  assign r_shift  = {r_q, q_q[bw-1]};
  assign trial_ge = (r_shift >= {1'b0, b_q});
  assign r_next   = trial_ge ? (r_shift[bw-1:0] - b_q) : r_shift[bw-1:0];
  assign q_next   = {q_q[bw-2:0], trial_ge};

`ifdef DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  // Divide magnitudes; quotient negative when signs differ, remainder follows dividend.
  assign a_mag    = A[bw-1] ? (~A + bw'(1)) : A;
  assign b_mag    = B[bw-1] ? (~B + bw'(1)) : B;
  assign quot_fix = neg_q_q ? (~q_next + bw'(1)) : q_next;
  assign rem_fix  = neg_r_q ? (~r_next + bw'(1)) : r_next;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if ((state_q != S_CALC) && start) begin
      neg_q_d = A[bw-1] ^ B[bw-1];
      neg_r_d = A[bw-1];
    end
  end
`else
  assign a_mag    = A;
  assign b_mag    = B;
  assign quot_fix = q_next;
  assign rem_fix  = r_next;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        done_d  = (state_q == S_DONE);
        state_d = S_IDLE;
        if (start) begin
          dbz_d = 1'b0;
          if (B == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            quot_d  = '1;
            rem_d   = A;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
            cnt_d   = CW'(bw - 1);
            r_d     = '0;
            q_d     = a_mag;
            b_d     = b_mag;
          end
        end
      end
      S_CALC: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          quot_d  = quot_fix;
          rem_d   = rem_fix;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed and random divisions against an arithmetic model.
`timescale 1ns/1ps
module tb_divider_seq;

  localparam int unsigned BW = 16;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] A = '0;
  logic [BW-1:0] B = '0;
  logic          busy;
  logic          done;
  logic [BW-1:0] quotient;
  logic [BW-1:0] remainder;
  logic          div_by_zero;

  int tests = 0;
  int fails = 0;

  divider_seq #(.bw(BW)) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  task automatic model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                       output logic [BW-1:0] q, output logic [BW-1:0] r, output logic z);
    z = 1'b0;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      if (a == 16'h8000 && b == 16'hFFFF) begin
        q = 16'h8000; r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the start edge.
  task automatic start_op(input logic [BW-1:0] a, input logic [BW-1:0] b);
    start = 1'b1; A = a; B = b;
    @(negedge CLK);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
  endtask

  // Waits (bounded) for done and checks latency, busy length and results.
  // poke_k >= 0 issues a stray start request during the computation.
  task automatic wait_done(input string tag, input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input int poke_k);
    int k = 0;
    int bc = 0;
    logic [BW-1:0] eq, er;
    logic ez;
    model(a, b, eq, er, ez);
    while (done !== 1'b1 && k < 60) begin
      if (busy === 1'b1) bc++;
      start = (k == poke_k);
      if (k == poke_k) begin A = 16'd9; B = 16'd3; end
      @(negedge CLK);
      k++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(k), (b == '0) ? 32'd1 : 32'(BW + 1));
    chk({tag, "_busy_cycles"}, 32'(bc), (b == '0) ? 32'd0 : 32'(BW));
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    int dcnt;
    logic [BW-1:0] ra, rb;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    RESETn = 1'b1;
    @(negedge CLK);

    // Basic division, then check done is a single-cycle pulse and results hold
    start_op(16'd100, 16'd7);
    wait_done("d100_7", 16'd100, 16'd7, -1);
    @(negedge CLK);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("hold_quot", 32'(quotient), 32'd14);

    // Extreme operands
    start_op(16'hFFFF, 16'd1);
    wait_done("dFFFF_1", 16'hFFFF, 16'd1, -1);
    start_op(16'd3, 16'hFFFF);
    wait_done("d3_FFFF", 16'd3, 16'hFFFF, -1);

    // Divide by zero
    start_op(16'd5, 16'd0);
    wait_done("d5_0", 16'd5, 16'd0, -1);

    // Start during CALC ignored; back-to-back start in the done cycle accepted
    start_op(16'd100, 16'd7);
    wait_done("ignore_busy_start", 16'd100, 16'd7, 4);
    start_op(16'd9, 16'd3);
    wait_done("back_to_back", 16'd9, 16'd3, -1);

    // Asynchronous reset mid-division
    start_op(16'd100, 16'd7);
    repeat (7) @(negedge CLK);
    #2 RESETn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_quot", 32'(quotient), 32'd0);
    chk("midrst_rem", 32'(remainder), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    dcnt = 0;
    repeat (25) begin
      @(negedge CLK);
      if (done === 1'b1) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    start_op(16'd1000, 16'd33);
    wait_done("post_reset", 16'd1000, 16'd33, -1);

`ifdef DIVIDER_SIGNED_EN
    start_op(16'hFFF9, 16'd2);
    wait_done("s_m7_2", 16'hFFF9, 16'd2, -1);
    start_op(16'h8000, 16'hFFFF);
    wait_done("s_ovf", 16'h8000, 16'hFFFF, -1);
    start_op(16'd100, 16'hFFF9);
    wait_done("s_100_m7", 16'd100, 16'hFFF9, -1);
`endif

    // Random operands, some back-to-back, occasional small or zero divisor
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      case (i % 4)
        0: rb = 16'($urandom_range(0, 15));
        1: rb = 16'($urandom);
        2: rb = 16'($urandom_range(1, 300));
        default: rb = 16'($urandom_range(0, 65535));
      endcase
      if (i % 3 == 0) @(negedge CLK);
      start_op(ra, rb);
      wait_done($sformatf("rnd%0d", i), ra, rb, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
